// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [6:0] seg_t;

   // All segments off
   localparam seg_t SEG_BLANK = 7'h7F;

   // Hex glyph table, entry n is the pattern for nibble value n (entry 15 first)
   localparam logic [15:0][6:0] HEX_PAT = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   // Per-digit "keep" mask for leading-zero suppression: a digit is kept when
   // it or any more significant nibble is nonzero. Digit 0 is always kept so
   // that a zero value still shows a single "0".
   function automatic logic [NUM_DIGITS-1:0] lead_zero_keep(input logic [15:0] v);
      logic [NUM_DIGITS-1:0] keep;
      keep[0] = 1'b1;
      keep[1] = |v[15:4];
      keep[2] = |v[15:8];
      keep[3] = |v[15:12];
      return keep;
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   output seg_t       seg_o
);

   // Table lookup into the shared glyph table
   always_comb begin
      seg_o = HEX_PAT[nib_i];
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a four-digit active-low
// seven-segment display. A 16-bit value is staged through load/ack and only
// committed to the displayed shadow register at the frame wrap, so a frame
// never mixes digits from two different values.
//
// Build option: define SEG7_LZ_BLANK_EN to suppress leading zeros.
//
// Handshake: load is a single-cycle strobe with no back-pressure; the value
// is always accepted (a later load while one is pending replaces it). ack
// pulses for one cycle, in the cycle the first digit of the new frame is
// shown, whenever a value becomes the displayed value.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value_in,
   input  logic        load,
   input  logic [3:0]  digit_en,
   output logic        ack,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   // Scan state
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic             terminal;
   logic             commit;

   // Value path state
   logic [15:0] staged_q, staged_d;
   logic        pending_q, pending_d;
   logic [15:0] shadow_q, shadow_d;

   // Registered outputs
   logic       ack_q, ack_d;
   seg_t       seg_q, seg_d;
   logic [3:0] an_q, an_d;

   // Display datapath
   logic [3:0]            cur_nib;
   seg_t                  cur_pat;
   logic [NUM_DIGITS-1:0] lz_keep;
   logic                  digit_on;

   assign terminal = (cnt_q == CNT_LAST);
   assign commit   = terminal && (idx_q == 2'd3);

   // Refresh counter and digit index advance
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (terminal) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end
   end

   // Staging, commit at frame wrap, and the same-cycle bypass
   always_comb begin
      staged_d  = staged_q;
      pending_d = pending_q;
      shadow_d  = shadow_q;
      ack_d     = 1'b0;
      if (load) begin
         staged_d  = value_in;
         pending_d = 1'b1;
      end
      if (commit) begin
         if (load) begin
            // A load on the wrap itself goes straight to the display
            shadow_d  = value_in;
            pending_d = 1'b0;
            ack_d     = 1'b1;
         end else if (pending_q) begin
            shadow_d  = staged_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
         end
      end
   end

   // Select the nibble for the digit that will be lit next cycle; using the
   // next-state index and shadow keeps seg/an aligned with idx after the edge
   always_comb begin
      cur_nib = shadow_d[{idx_d, 2'b00} +: 4];
   end

   hex_to_seg7 u_dec (
      .nib_i (cur_nib),
      .seg_o (cur_pat)
   );

   // Leading-zero suppression mask (all digits kept when the option is off)
   always_comb begin
`ifdef SEG7_LZ_BLANK_EN
      lz_keep = lead_zero_keep(shadow_d);
`else
      lz_keep = '1;
`endif
   end

   // Anode and segment selection with per-digit blanking
   always_comb begin
      digit_on = digit_en[idx_d] & lz_keep[idx_d];
      an_d     = 4'hF;
      seg_d    = SEG_BLANK;
      if (digit_on) begin
         an_d  = ~(4'b0001 << idx_d);
         seg_d = cur_pat;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         idx_q     <= 2'd0;
         staged_q  <= 16'h0000;
         pending_q <= 1'b0;
         shadow_q  <= 16'h0000;
         ack_q     <= 1'b0;
         seg_q     <= SEG_BLANK;
         an_q      <= 4'hF;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         staged_q  <= staged_d;
         pending_q <= pending_d;
         shadow_q  <= shadow_d;
         ack_q     <= ack_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign ack = ack_q;
   assign seg = seg_q;
   assign an  = an_q;
   assign dp  = 1'b1;

endmodule
